// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, fetches words over req/ack and hands {inst, pc+4, valid} to IF/ID.
// Latency: a word is presented the cycle after its ack; with N memory wait cycles, one word per N+1 cycles.
// Backpressure: hz_i freezes the output slot; one extra word parks in a skid entry and fetch pauses until it drains.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hz_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  // FETCH: request outstanding at fa_q. HOLD: skid entry full, no request.
  // DRAIN: a wrong-path request is still outstanding and must complete before
  // the redirect target can be requested.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_t;

  localparam logic [31:0] RESET_FA = RESET_PC & ~32'h3;

  state_e      state_q;
  logic [31:0] fa_q;
  logic [31:0] tgt_q;
  slot_t       pend_q;
  slot_t       out_q;
  logic        out_vld_q;

  logic [31:0] br_tgt;
  logic [31:0] fa_inc;
  logic        slot_free;
  logic        consumed;

  // Targets are forced to word alignment; PC arithmetic wraps modulo 2^32.
  assign br_tgt    = branch_addr_i & ~32'h3;
  assign fa_inc    = fa_q + 32'd4;
  assign slot_free = !out_vld_q || !hz_i;
  assign consumed  = out_vld_q && !hz_i;

  // The request is a pure function of state so it cannot drop while waiting for ack.
  assign imem_req_o   = rst_i && (state_q == FETCH || state_q == DRAIN);
  assign imem_addr_o  = fa_q;
  assign inst_o       = out_q.inst;
  assign pc_o         = out_q.pc;
  assign inst_valid_o = out_vld_q;

  // Fetch FSM with registered output slot; priority is reset, branch, ack, stall.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= FETCH;
      fa_q      <= RESET_FA;
      tgt_q     <= '0;
      pend_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (branch_i) begin
            out_vld_q <= 1'b0;
            if (imem_ack_i) begin
              // Data returning this cycle is wrong-path; drop it and go straight to the target.
              fa_q <= br_tgt;
            end else begin
              // Address must stay put until the in-flight request completes.
              tgt_q   <= br_tgt;
              state_q <= DRAIN;
            end
          end else if (imem_ack_i) begin
            fa_q <= fa_inc;
            if (slot_free) begin
              out_q     <= '{inst: imem_data_i, pc: fa_inc};
              out_vld_q <= 1'b1;
            end else begin
              pend_q  <= '{inst: imem_data_i, pc: fa_inc};
              state_q <= HOLD;
            end
          end else if (consumed) begin
            out_vld_q <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_i) begin
            pend_q    <= '0;
            out_vld_q <= 1'b0;
            fa_q      <= br_tgt;
            state_q   <= FETCH;
          end else if (!hz_i) begin
            // Output is consumed this edge; the skid word replaces it with no bubble.
            out_q   <= pend_q;
            state_q <= FETCH;
          end
        end

        DRAIN: begin
          if (imem_ack_i) begin
            fa_q    <= branch_i ? br_tgt : tgt_q;
            state_q <= FETCH;
          end else if (branch_i) begin
            tgt_q <= br_tgt;
          end
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Bench for fetch_unit: variable-latency memory model plus an in-order scoreboard of consumed slots.
// Latency: expected slots are pushed when a scenario starts and popped when IF/ID would consume one.
// Backpressure: hz_i and branch_i are driven from per-cycle scenario loops.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } slot_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hz_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int    n_cmp = 0;
  int    n_err = 0;
  int    lat   = 0;
  int    wcnt  = 0;
  slot_t exp_q[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .hz_i         (hz_i),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: ack in the lat-th cycle after req rises; a dropped req abandons the transaction.
  assign imem_ack_i  = imem_req_o && (wcnt == lat);
  assign imem_data_i = imem_addr_o ^ 32'hA5A5_0000;

  always @(posedge clk_i) begin
    if (!imem_req_o || imem_ack_i) wcnt <= 0;
    else                           wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] a);
    slot_t s;
    s.inst = a ^ 32'hA5A5_0000;
    s.pc   = a + 32'd4;
    exp_q.push_back(s);
  endfunction

  // Scoreboard pop on every consumption, plus req/addr stability while a request waits.
  always @(negedge clk_i) begin
    slot_t e;
    if (rst_i && inst_valid_o && !hz_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_inst", inst_o, e.inst);
      chk("sb_pc", pc_o, e.pc);
    end
    if (prev_wait && rst_i) begin
      chk("mem_req_hold", {31'd0, imem_req_o}, 32'd1);
      chk("mem_addr_hold", imem_addr_o, prev_addr);
    end
    prev_wait = rst_i && imem_req_o && !imem_ack_i;
    prev_addr = imem_addr_o;
  end

  // Called at a drive point; returns at the drive point of the first cycle after release.
  task automatic do_reset(input int l);
    rst_i    = 1'b0;
    hz_i     = 1'b0;
    branch_i = 1'b0;
    lat      = l;
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_vld", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    hz_i     = 1'b0;
    branch_i = 1'b0;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int         vcnt;
    int         held;
    logic [9:0] vpat;

    rst_i = 1'b0; hz_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    @(posedge clk_i);
    #1;

    // Zero-wait streaming: one instruction per cycle from RESET_PC.
    do_reset(0);
    for (int a = 0; a < 8; a++) push_exp(32'(4 * a));
    vcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        chk("s1_req", {31'd0, imem_req_o}, 32'd1);
        chk("s1_addr", imem_addr_o, 32'h0);
        chk("s1_vld0", {31'd0, inst_valid_o}, 32'd0);
      end
      if (c == 2) begin
        chk("s1_inst", inst_o, 32'hA5A5_0000);
        chk("s1_pc", pc_o, 32'h4);
      end
      if (c >= 2 && inst_valid_o) vcnt++;
      @(posedge clk_i);
      #1;
    end
    chk("s1_rate", vcnt, 32'd8);
    wait_drain("s1_drain");

    // Two wait cycles: address held three cycles, one valid pulse every three.
    do_reset(2);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    vpat = '0;
    held = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      vpat[c-1] = inst_valid_o;
      if (c <= 3 && imem_req_o && imem_addr_o == 32'h0) held++;
      @(posedge clk_i);
      #1;
    end
    chk("s2_hold", held, 32'd3);
    chk("s2_vpat", {22'd0, vpat}, 32'h248);
    wait_drain("s2_drain");

    // Stall while inst@0x8 is presented: 0xC goes to skid, fetch pauses, no gap on release.
    do_reset(0);
    for (int a = 0; a < 6; a++) push_exp(32'(4 * a));
    for (int c = 1; c <= 10; c++) begin
      hz_i = (c >= 4 && c <= 6);
      @(negedge clk_i);
      if (c >= 4 && c <= 7) begin
        chk("s3_hold_inst", inst_o, 32'hA5A5_0008);
        chk("s3_hold_pc", pc_o, 32'hC);
        chk("s3_hold_vld", {31'd0, inst_valid_o}, 32'd1);
      end
      if (c == 5 || c == 6) chk("s3_req_low", {31'd0, imem_req_o}, 32'd0);
      if (c == 8) chk("s3_pend_inst", inst_o, 32'hA5A5_000C);
      if (c == 9) chk("s3_next_inst", inst_o, 32'hA5A5_0010);
      @(posedge clk_i);
      #1;
    end
    wait_drain("s3_drain");

    // Redirect while the 0x10 request waits: it completes, is discarded, then 0x100 is fetched.
    do_reset(3);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h100);
    branch_addr_i = 32'h0000_0103;
    for (int c = 1; c <= 25; c++) begin
      branch_i = (c == 18);
      @(negedge clk_i);
      if (c >= 18 && c <= 20) begin
        chk("s4_drain_req", {31'd0, imem_req_o}, 32'd1);
        chk("s4_drain_addr", imem_addr_o, 32'h10);
      end
      if (c >= 18 && c <= 24) chk("s4_vld_low", {31'd0, inst_valid_o}, 32'd0);
      if (c == 21) begin
        chk("s4_redir_req", {31'd0, imem_req_o}, 32'd1);
        chk("s4_redir_addr", imem_addr_o, 32'h100);
      end
      if (c == 25) begin
        chk("s4_tgt_inst", inst_o, 32'hA5A5_0100);
        chk("s4_tgt_pc", pc_o, 32'h104);
      end
      @(posedge clk_i);
      #1;
    end
    wait_drain("s4_drain");

    // Branch together with stall in HOLD: skid and output both dropped.
    do_reset(0);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h100); push_exp(32'h104);
    branch_addr_i = 32'h0000_0100;
    for (int c = 1; c <= 7; c++) begin
      hz_i     = (c == 4 || c == 5);
      branch_i = (c == 5);
      @(negedge clk_i);
      if (c == 5) chk("s5_hold_req", {31'd0, imem_req_o}, 32'd0);
      if (c == 6) begin
        chk("s5_vld_low", {31'd0, inst_valid_o}, 32'd0);
        chk("s5_req", {31'd0, imem_req_o}, 32'd1);
        chk("s5_addr", imem_addr_o, 32'h100);
      end
      if (c == 7) begin
        chk("s5_inst", inst_o, 32'hA5A5_0100);
        chk("s5_pc", pc_o, 32'h104);
      end
      @(posedge clk_i);
      #1;
    end
    wait_drain("s5_drain");

    // Branch coinciding with ack in FETCH, to an unaligned top-of-memory target that wraps.
    do_reset(0);
    push_exp(32'h0); push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    branch_addr_i = 32'hFFFF_FFFE;
    for (int c = 1; c <= 6; c++) begin
      hz_i     = (c == 3);
      branch_i = (c == 3);
      @(negedge clk_i);
      if (c == 4) begin
        chk("s6_vld_low", {31'd0, inst_valid_o}, 32'd0);
        chk("s6_addr", imem_addr_o, 32'hFFFF_FFFC);
      end
      if (c == 5) begin
        chk("s6_wrap_inst", inst_o, 32'h5A5A_FFFC);
        chk("s6_wrap_pc", pc_o, 32'h0);
      end
      if (c == 6) chk("s6_after_wrap", imem_addr_o, 32'h4);
      @(posedge clk_i);
      #1;
    end
    wait_drain("s6_drain");

    // Reset pulse during a wait: request drops, fetch restarts at RESET_PC.
    do_reset(2);
    push_exp(32'h0);
    for (int c = 1; c <= 6; c++) begin
      rst_i = (c != 5);
      if (c == 6) begin
        push_exp(32'h0);
        push_exp(32'h4);
      end
      @(negedge clk_i);
      if (c == 4) chk("s7_wait_addr", imem_addr_o, 32'h4);
      if (c == 5) chk("s7_rst_req", {31'd0, imem_req_o}, 32'd0);
      if (c == 6) begin
        chk("s7_vld", {31'd0, inst_valid_o}, 32'd0);
        chk("s7_req", {31'd0, imem_req_o}, 32'd1);
        chk("s7_addr", imem_addr_o, 32'h0);
      end
      @(posedge clk_i);
      #1;
    end
    wait_drain("s7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a req/ack handshake with variable latency. It presents each fetched instruction with its PC+4 and a valid flag to IF/ID. It honours load-use hazard stalls from ID and redirects fetch on taken branches or jumps, discarding any wrong-path data that is still in flight.

## Interface
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-low
- hz_i  in  1  hazard stall from ID; the output slot must hold
- branch_i  in  1  taken branch/jump redirect from ID (one-cycle pulse)
- branch_addr_i  in  32  redirect target, valid with branch_i
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  32  fetch address, word aligned
- imem_ack_i  in  1  memory has returned data this cycle
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- inst_o  out  32  instruction to IF/ID (read_data_i)
- pc_o  out  32  address of inst_o + 4 (IF/ID pc_i)
- inst_valid_o  out  1  inst_o/pc_o valid; drives IF/ID pcEnable_i

## Operation
- State: fa_q (fetch address), tgt_q (pending redirect), pend_q/pend_pc_q (one-entry skid), output registers, and FSM {FETCH, HOLD, DRAIN}.
- imem_req_o = rst_i && (state==FETCH || state==DRAIN); imem_addr_o = fa_q.
- Memory rule: once req is high, req and addr stay stable until the cycle in which ack is high.
- Output slot "free" = !inst_valid_o || !hz_i. An instruction is consumed at an edge where inst_valid_o && !hz_i.
- FETCH:
  - branch_i: fa_q<=branch_addr_i; inst_valid_o<=0. If ack is high that cycle, discard the data and stay in FETCH. Otherwise tgt_q<=branch_addr_i and go to DRAIN, with fa_q held.
  - ack, slot free: inst_o<=data, pc_o<=fa_q+4, inst_valid_o<=1, fa_q<=fa_q+4.
  - ack, slot not free: pend_q<=data, pend_pc_q<=fa_q+4, fa_q<=fa_q+4, go to HOLD.
  - no ack, slot free and valid consumed: inst_valid_o<=0.
- HOLD (req low):
  - branch_i: drop pend and output (inst_valid_o<=0), fa_q<=branch_addr_i, go to FETCH.
  - !hz_i: output<=pend, inst_valid_o stays 1, go to FETCH.
- DRAIN (req high, fa_q is the old address):
  - branch_i: tgt_q<=branch_addr_i.
  - ack: discard the data, fa_q<=tgt_q (or branch_addr_i if branch_i is high the same cycle), go to FETCH.
  - inst_valid_o stays 0 throughout.
- Priority: reset > branch_i > ack > hz_i.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0. Low two bits of branch_addr_i are forced to 0.

## Timing
- Reset values (rst_i low at an edge): state=FETCH, fa_q=RESET_PC, tgt_q=0, pend=0, inst_o=0, pc_o=0, inst_valid_o=0. imem_req_o is 0 while rst_i is low.
- Reset mid-request abandons the transaction; the memory model must drop it.
- Zero-wait memory (ack in the same cycle as req): inst_valid_o rises the cycle after the first ack, then one instruction per cycle.
- N wait cycles: ack arrives in the Nth cycle after req rises; throughput is one instruction per N+1 cycles.
- Stall: inst_o/pc_o/inst_valid_o are unchanged while hz_i is high. At most one extra instruction is buffered (pend). No instruction is lost or duplicated.
- Redirect: first request to the target is issued the cycle after branch_i (FETCH), or the cycle after the draining ack (DRAIN). Wrong-path data never reaches inst_valid_o=1.

## Test plan
- Reset, RESET_PC=0, ack tied high, data=addr^0xA5A5_0000: addresses 0,4,8,…; first inst_valid_o one cycle after reset release with inst_o=0xA5A5_0000, pc_o=4; one instruction per cycle.
- Memory latency 2: addr 0 held for 3 cycles with req high; inst_valid_o pulses once per 3 cycles; pc_o=4,8,12.
- Zero-wait, hz_i high for 3 cycles while inst@0x8 is valid: output holds 0x8; inst@0xC lands in pend; req low in HOLD. After release, 0xC appears the next cycle, then 0x10. No gaps or repeats.
- branch_i to 0x100 while the request to 0x10 waits 3 cycles: req/addr stay at 0x10 until ack; that data is discarded; next request addr=0x100; inst_valid_o stays 0 until the 0x100 data returns, then pc_o=0x104.
- branch_i and hz_i high together in HOLD: pend and output are dropped, inst_valid_o=0, next request addr=0x100.
- rst_i low for one cycle during a wait: next cycle req=0 and inst_valid_o=0; after release, fetch restarts at RESET_PC.
